// File: rtl/uart_loader.sv
// uart_loader: receives a length-prefixed 8N1 UART image and writes it word by word into program RAM, holding the CPU in reset until loading completes.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  cpu_reset,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] LD_LEN_LO = 2'd0, LD_LEN_HI = 2'd1, LD_DATA = 2'd2, LD_DONE = 2'd3;

  logic                  sync1_q, sync2_q;
  logic [1:0]            rx_st_q, rx_st_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  ferr_q, ferr_d;
  logic                  byte_valid;
  logic [1:0]            ld_st_q, ld_st_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           words_q, words_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;

  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    byte_valid = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) rx_st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d   = '0;
        bit_d   = '0;
        rx_st_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL_LAST) begin
        cnt_d   = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      default: if (cnt_q == FULL_LAST) begin
        rx_st_d    = RX_IDLE;
        byte_valid = sync2_q;
        ferr_d     = ferr_q | ~sync2_q;
      end
    endcase
  end

  // The write strobe cycle advances the address and word count; the last word moves to DONE.
  always_comb begin
    ld_st_d = ld_st_q;
    len_d   = len_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    if (we_q) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q + 16'd1;
      if (words_q == len_q - 16'd1) ld_st_d = LD_DONE;
    end
    if (byte_valid)
      case (ld_st_q)
        LD_LEN_LO: begin
          len_d[7:0] = shift_q;
          ld_st_d    = LD_LEN_HI;
        end
        LD_LEN_HI: begin
          len_d[15:8] = shift_q;
          ld_st_d     = ({shift_q, len_q[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
        end
        LD_DATA: begin
          wdata_d[{bidx_q, 3'b000} +: 8] = shift_q;
          bidx_d = bidx_q + 2'd1;
          we_d   = (bidx_q == 2'd3);
        end
        default: ;
      endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ld_st_q <= LD_LEN_LO;
      len_q   <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ld_st_q <= ld_st_d;
      len_q   <= len_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  assign cpu_reset = (ld_st_q != LD_DONE);
  assign done      = (ld_st_q == LD_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed UART load scenarios with hand-computed RAM writes and status flags.
module tb_uart_loader;
  localparam int CPB = 16;
  localparam int AW  = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          cpu_reset, mem_we, done, frame_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  int total = 0, bad = 0;
  int cyc = 0, we_hi = 0, we_pulses = 0, last_we_cyc = -1, done_cyc = -1;
  logic we_prev = 1'b0, done_prev = 1'b0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cpu_reset(cpu_reset), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      we_hi++;
      if (!we_prev) we_pulses++;
      last_we_cyc = cyc;
    end
    we_prev = mem_we;
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    we_hi = 0;
    we_pulses = 0;
    last_we_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cpu_reset, mem_we, mem_addr, mem_wdata, done, frame_err} !== {1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got %b_%b_%h_%h_%b_%b want 1_0_0_00000000_0_0", cpu_reset, mem_we, mem_addr, mem_wdata, done, frame_err);
    end
    @(posedge clk);
    reset = 1'b0;
    clear_mon();
    @(negedge clk);
    total++;
    if ({cpu_reset, mem_we, mem_addr, mem_wdata, done, frame_err} !== {1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release: got %b_%b_%h_%h_%b_%b want 1_0_0_00000000_0_0", cpu_reset, mem_we, mem_addr, mem_wdata, done, frame_err);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (we_pulses !== 2 || we_hi !== 2) begin
      bad++;
      $display("FAIL two_pulses: got pulses=%0d high_cycles=%0d want 2 2", we_pulses, we_hi);
    end
    total++;
    if (wa[0] !== 4'h0 || wd[0] !== 32'h12345678) begin
      bad++;
      $display("FAIL two_w0: got %h:%h want 0:12345678", wa[0], wd[0]);
    end
    total++;
    if (wa[1] !== 4'h1 || wd[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL two_w1: got %h:%h want 1:deadbeef", wa[1], wd[1]);
    end
    total++;
    if (done_cyc !== last_we_cyc + 1) begin
      bad++;
      $display("FAIL two_done_timing: got done cycle %0d want %0d", done_cyc, last_we_cyc + 1);
    end
    total++;
    if ({done, cpu_reset, frame_err} !== 3'b100) begin
      bad++;
      $display("FAIL two_status: got %b want 100", {done, cpu_reset, frame_err});
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b1);
    total++;
    if ({done, cpu_reset} !== 2'b01) begin
      bad++;
      $display("FAIL zero_mid: got %b want 01", {done, cpu_reset});
    end
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    total++;
    if ({done, cpu_reset} !== 2'b10 || we_hi !== 0) begin
      bad++;
      $display("FAIL zero_done: got done_cpu=%b writes=%0d want 10 0", {done, cpu_reset}, we_hi);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h00000001);
    @(negedge clk);
    total++;
    if (we_hi !== 1 || wa[0] !== 4'h0 || wd[0] !== 32'h00000001) begin
      bad++;
      $display("FAIL glitch_write: got n=%0d %h:%h want 1 0:00000001", we_hi, wa[0], wd[0]);
    end
    total++;
    if ({done, frame_err} !== 2'b10) begin
      bad++;
      $display("FAIL glitch_status: got %b want 10", {done, frame_err});
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b0);
    total++;
    if (frame_err !== 1'b1 || we_hi !== 0) begin
      bad++;
      $display("FAIL ferr_flag: got ferr=%b writes=%0d want 1 0", frame_err, we_hi);
    end
    send_word(32'h44332211);
    @(negedge clk);
    total++;
    if (we_hi !== 1 || wa[0] !== 4'h0 || wd[0] !== 32'h44332211) begin
      bad++;
      $display("FAIL ferr_write: got n=%0d %h:%h want 1 0:44332211", we_hi, wa[0], wd[0]);
    end
    chk("ferr_status", {62'd0, done, frame_err}, 64'd3);
  endtask

  task automatic test_wrap();
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 17; i++) send_word(i);
    @(negedge clk);
    total++;
    if (we_pulses !== 17 || we_hi !== 17) begin
      bad++;
      $display("FAIL wrap_count: got pulses=%0d high_cycles=%0d want 17 17", we_pulses, we_hi);
    end
    total++;
    if (wa[15] !== 4'hF || wd[15] !== 32'h0000000F) begin
      bad++;
      $display("FAIL wrap_w15: got %h:%h want f:0000000f", wa[15], wd[15]);
    end
    total++;
    if (wa[16] !== 4'h0 || wd[16] !== 32'h00000010) begin
      bad++;
      $display("FAIL wrap_w16: got %h:%h want 0:00000010", wa[16], wd[16]);
    end
    send_word(32'hCAFEF00D);
    @(negedge clk);
    total++;
    if (we_hi !== 17 || {done, cpu_reset} !== 2'b10) begin
      bad++;
      $display("FAIL wrap_after_done: got writes=%0d done_cpu=%b want 17 10", we_hi, {done, cpu_reset});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (we_hi !== 0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_write: got writes=%0d we=%b want 0 0", we_hi, mem_we);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    clear_mon();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'hDDCCBBAA);
    @(negedge clk);
    total++;
    if (we_hi !== 1 || wa[0] !== 4'h0 || wd[0] !== 32'hDDCCBBAA) begin
      bad++;
      $display("FAIL mid_reload: got n=%0d %h:%h want 1 0:ddccbbaa", we_hi, wa[0], wd[0]);
    end
    chk("mid_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_glitch();
    test_frame_err();
    test_reset();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the width of the word address to program RAM.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port rx  input  1  asynchronous UART receive line, idle high.
REQ-006 The block SHALL have port cpu_reset  output  1  holds the CPU in reset while loading.
REQ-007 The block SHALL have port mem_we  output  1  one-cycle RAM write strobe.
REQ-008 The block SHALL have port mem_addr  output  ADDR_WIDTH  RAM word address.
REQ-009 The block SHALL have port mem_wdata  output  32  RAM write data.
REQ-010 The block SHALL have port done  output  1  load complete.
REQ-011 The block SHALL have port frame_err  output  1  sticky framing-error flag.

Function
REQ-012 The block SHALL pass rx through a two-flop synchronizer before any use.
REQ-013 RX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE: on synchronized rx=0, go to START and clear the bit timer.
REQ-014 START SHALL wait CLKS_PER_BIT/2 cycles, then sample rx.
- rx=0: go to DATA.
- rx=1 (glitch): return to IDLE with no byte.
REQ-015 DATA SHALL sample 8 bits LSB first, one every CLKS_PER_BIT cycles.
REQ-016 STOP SHALL sample rx after CLKS_PER_BIT cycles, then return to IDLE.
- rx=1: pulse an internal byte_valid for exactly one cycle.
- rx=0: drop the byte and set frame_err.
REQ-017 Load FSM states SHALL be LEN_LO, LEN_HI, DATA, DONE; it consumes only byte_valid bytes.
REQ-018 LEN_LO/LEN_HI SHALL capture a 16-bit little-endian word count N.
- N=0: go directly to DONE.
- N>0: go to DATA.
REQ-019 DATA SHALL assemble each 4 consecutive bytes into mem_wdata, little-endian (first byte = bits 7:0).
REQ-020 mem_we SHALL pulse high for exactly one cycle, the cycle after the byte_valid of the 4th byte of a word, with mem_addr and mem_wdata stable during that cycle.
REQ-021 mem_addr SHALL start at 0 and increment by 1 after each write, wrapping modulo 2^ADDR_WIDTH when N exceeds RAM depth.
REQ-022 After the Nth word write, the block SHALL enter DONE on the following cycle.
- In that same cycle: done goes to 1 and cpu_reset goes to 0.
REQ-023 In DONE, all further received bytes SHALL be ignored and mem_we SHALL stay 0 until reset.
REQ-024 frame_err SHALL NOT abort loading; a dropped byte is simply not counted.
REQ-025 The word-count and byte-index counters SHALL be at least 16 and 2 bits respectively, with no overflow for N up to 65535.

Reset
REQ-026 While reset=1, and on the first cycle after reset is released, the outputs SHALL be:
- cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, frame_err=0.
- RX FSM in IDLE, load FSM in LEN_LO.
REQ-027 Reset asserted mid-byte or mid-load SHALL abandon all partial data, with no write issued on the reset cycle.
- The next load restarts at LEN_LO with address 0.
REQ-028 The synchronizer flops SHALL reset to 1 (idle line).

Verification (CLKS_PER_BIT=16, ADDR_WIDTH=4)
REQ-029 Send bytes 02 00 78 56 34 12 EF BE AD DE:
- Two mem_we pulses: addr 0 data 12345678, addr 1 data DEADBEEF.
- done=1 and cpu_reset=0 one cycle after the second pulse.
REQ-030 Send 00 00:
- No mem_we pulse.
- done=1 and cpu_reset=0 one cycle after the 2nd byte's byte_valid.
REQ-031 Drive an rx low pulse of 4 cycles, then send a normal load of N=1, word 00000001:
- No spurious byte is received.
- A single write at addr 0 of 00000001.
REQ-032 Send 01 00, then a byte with stop bit 0, then 11 22 33 44:
- frame_err=1.
- One write at addr 0 of 44332211.
REQ-033 Send N=17 (11 00) followed by words 0..16:
- The 17th write goes to addr 0 with data 00000010.
- After done, an extra 4 bytes produce no write.
REQ-034 Assert reset after 3 of 4 data bytes, then send 01 00 AA BB CC DD:
- No write before reset.
- After reset, one write at addr 0 of DDCCBBAA.
